// File: rtl/inst_mem_loader.sv
// inst_mem_loader: takes 32-bit words over valid/ready and writes each one into the
// byte-wide instruction memory as four little-endian byte writes, one byte per cycle.
module inst_mem_loader #(
    parameter int MEM_BYTES = 16,
    parameter int COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [63:0]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               word_valid,
    input  logic [31:0]        word_data,
    output logic               word_ready,
    output logic               mem_we,
    output logic [63:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int SUM_W = 64 + COUNT_W + 2;
    typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;
    state_t             r_state;
    state_t             w_next;
    logic [63:0]        r_addr_ptr;
    logic [COUNT_W-1:0] r_remaining;
    logic [31:0]        r_shift;
    logic [1:0]         r_byte_idx;
    logic               r_error;
    logic [SUM_W-1:0]   w_end;
    logic               w_reject;
    logic               w_accept;
    logic               w_handshake;
    logic               w_writing;
    // End of the load computed wide enough that a huge base or count cannot wrap.
    assign w_end       = SUM_W'(base_addr) + (SUM_W'(word_count) << 2);
    assign w_reject    = (|base_addr[1:0]) || (w_end > SUM_W'(MEM_BYTES));
    assign w_accept    = (r_state == IDLE) && start && !w_reject;
    assign w_handshake = (r_state == WAIT_WORD) && word_valid;
    assign w_writing   = r_state == WRITE;
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_accept ? ((word_count == '0) ? DONE : WAIT_WORD) : IDLE;
            WAIT_WORD: w_next = word_valid ? WRITE : WAIT_WORD;
            WRITE:     w_next = (r_byte_idx != 2'd3) ? WRITE :
                                (r_remaining == COUNT_W'(1)) ? DONE : WAIT_WORD;
            default:   w_next = IDLE;
        endcase
        word_ready = r_state == WAIT_WORD;
        mem_we     = w_writing;
        mem_addr   = w_writing ? r_addr_ptr : '0;
        mem_wdata  = w_writing ? r_shift[7:0] : '0;
        busy       = r_state != IDLE;
        done       = r_state == DONE;
        error      = r_error;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_ptr  <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= (r_state == IDLE) && start && w_reject;
            if (w_accept) begin
                r_addr_ptr  <= base_addr;
                r_remaining <= word_count;
            end
            if (w_handshake) begin
                r_shift    <= word_data;
                r_byte_idx <= '0;
            end
            if (w_writing) begin
                r_addr_ptr <= r_addr_ptr + 64'd1;
                r_shift    <= r_shift >> 8;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3)
                    r_remaining <= r_remaining - COUNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed loads checked every cycle against a cycle-keyed
// expectation model derived from the loader's timing rules, plus literal memory images.
module tb_inst_mem_loader;
    localparam int MEM = 16;
    localparam int CW  = 8;
    logic          clk;
    logic          reset;
    logic          start;
    logic [63:0]   base_addr;
    logic [CW-1:0] word_count;
    logic          word_valid;
    logic [31:0]   word_data;
    logic          word_ready;
    logic          mem_we;
    logic [63:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          error;

    inst_mem_loader #(.MEM_BYTES(MEM), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] imem [MEM];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_we === 1'b1 && mem_addr < 64'(MEM)) imem[mem_addr[3:0]] <= mem_wdata;

    // Expectations keyed by cycle number; an open-ended wait for the next word is
    // tracked separately because its length depends on when the source offers data.
    logic [63:0] e_addr [int];
    logic [7:0]  e_data [int];
    bit          e_ready [int];
    bit          e_busy [int];
    bit          e_done [int];
    bit          e_err [int];
    bit          m_wait = 1'b0;
    int          m_ready_from = 0;
    int          m_busy_end = 0;
    int          m_left = 0;
    logic [63:0] m_addr = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_start(input int t, input logic [63:0] b, input int n);
        logic [73:0] s;
        s = 74'(b) + 74'(n) * 74'd4;
        if (b[1:0] != 2'b00 || s > 74'(MEM)) begin
            e_err[t+1] = 1'b1;
            return;
        end
        m_addr = b;
        m_left = n;
        if (n == 0) begin
            e_busy[t+1] = 1'b1;
            e_done[t+1] = 1'b1;
            m_busy_end = t + 1;
        end else begin
            m_ready_from = t + 1;
            m_wait = 1'b1;
        end
    endfunction

    function automatic void model_word(input int v, input logic [31:0] d, output int n);
        n = (v > m_ready_from) ? v : m_ready_from;
        for (int c = m_ready_from; c <= n; c++) begin
            e_ready[c] = 1'b1;
            e_busy[c] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            e_addr[n+1+k] = m_addr + 64'(k);
            e_data[n+1+k] = d[8*k +: 8];
            e_busy[n+1+k] = 1'b1;
        end
        m_addr += 64'd4;
        m_left--;
        if (m_left == 0) begin
            e_done[n+5] = 1'b1;
            e_busy[n+5] = 1'b1;
            m_busy_end = n + 5;
            m_wait = 1'b0;
        end else begin
            m_ready_from = n + 5;
            m_wait = 1'b1;
        end
    endfunction

    function automatic void model_reset(input int r);
        if (m_wait)
            for (int c = m_ready_from; c <= r; c++) begin
                e_ready[c] = 1'b1;
                e_busy[c] = 1'b1;
            end
        for (int c = r + 1; c <= r + 64; c++) begin
            if (e_addr.exists(c)) e_addr.delete(c);
            if (e_data.exists(c)) e_data.delete(c);
            if (e_ready.exists(c)) e_ready.delete(c);
            if (e_busy.exists(c)) e_busy.delete(c);
            if (e_done.exists(c)) e_done.delete(c);
            if (e_err.exists(c)) e_err.delete(c);
        end
        m_wait = 1'b0;
        m_busy_end = r;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            automatic int c = cyc;
            automatic bit wr = e_addr.exists(c);
            automatic bit bz = e_busy.exists(c) || (m_wait && c >= m_ready_from);
            chk("word_ready", word_ready, e_ready.exists(c) || (m_wait && c >= m_ready_from));
            chk("busy", busy, bz);
            chk("mem_we", mem_we, wr);
            chk("done", done, e_done.exists(c));
            chk("error", error, e_err.exists(c));
            if (wr) begin
                chk("mem_addr", mem_addr, e_addr[c]);
                chk("mem_wdata", mem_wdata, e_data[c]);
            end else if (!bz) begin
                chk("idle_mem_addr", mem_addr, 64'd0);
                chk("idle_mem_wdata", mem_wdata, 8'd0);
            end
            we_cnt += int'(mem_we === 1'b1);
            done_cnt += int'(done === 1'b1);
            err_cnt += int'(error === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] b, input int n);
        start = 1'b1;
        base_addr = b;
        word_count = CW'(n);
        model_start(cyc, b, n);
        tick();
        start = 1'b0;
    endtask

    // gap > 0 keeps word_valid low for that many cycles after the loader becomes ready.
    task automatic send_word(input logic [31:0] d, input int gap);
        int n;
        int v;
        if (gap > 0) begin
            word_valid = 1'b0;
            while (cyc < m_ready_from + gap) tick();
        end
        v = cyc;
        word_valid = 1'b1;
        word_data = d;
        model_word(v, d, n);
        repeat (n - v + 1) tick();
    endtask

    task automatic wait_idle();
        word_valid = 1'b0;
        while (cyc <= m_busy_end + 1) tick();
    endtask

    task automatic check_image(input string name);
        logic [7:0] img [MEM];
        foreach (img[i]) img[i] = 8'h00;
        foreach (e_addr[c]) img[e_addr[c][3:0]] = e_data[c];
        for (int i = 0; i < MEM; i++) chk(name, imem[i], img[i]);
    endtask

    logic [31:0] prog [4] = '{32'h0F053483, 32'h009A84B3, 32'h00148493, 32'h0E953823};
    logic [7:0]  lit1 [16] = '{8'h83, 8'h34, 8'h05, 8'h0F, 8'hB3, 8'h84, 8'h9A, 8'h00,
                               8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h38, 8'h95, 8'h0E};
    logic [7:0]  lit_be [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0]  lit_rst [4] = '{8'hD4, 8'hC3, 8'h05, 8'h0F};
    logic [7:0]  lit_new [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

    initial begin
        int we0;
        int d0;
        int e0;
        int n;
        foreach (imem[i]) imem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        word_valid = 1'b0;
        word_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", word_ready, 1'b0);
        chk("reset_we", mem_we, 1'b0);
        tick();

        we0 = we_cnt; d0 = done_cnt;
        do_start(64'd0, 4);
        for (int i = 0; i < 4; i++) send_word(prog[i], 0);
        wait_idle();
        for (int i = 0; i < 16; i++) chk("load4_byte", imem[i], lit1[i]);
        chk("load4_word_at_8", {imem[11], imem[10], imem[9], imem[8]}, 32'h00148493);
        chk("load4_we_cycles", 64'(we_cnt - we0), 64'd16);
        chk("load4_done_count", 64'(done_cnt - d0), 64'd1);
        check_image("load4_image");

        we0 = we_cnt; e0 = err_cnt;
        do_start(64'd4, 2);
        send_word(32'h11223344, 3);
        start = 1'b1;
        base_addr = 64'd2;
        word_count = 8'd1;
        tick();
        start = 1'b0;
        send_word(32'h55667788, 3);
        wait_idle();
        chk("bp_err_count", 64'(err_cnt - e0), 64'd0);
        chk("bp_we_cycles", 64'(we_cnt - we0), 64'd8);
        chk("bp_word_at_4", {imem[7], imem[6], imem[5], imem[4]}, 32'h11223344);
        chk("bp_word_at_8", {imem[11], imem[10], imem[9], imem[8]}, 32'h55667788);
        check_image("bp_image");

        we0 = we_cnt; e0 = err_cnt;
        do_start(64'd2, 1);
        tick();
        chk("rej_misaligned_err", 64'(err_cnt - e0), 64'd1);
        do_start(64'd12, 2);
        tick();
        chk("rej_overflow_err", 64'(err_cnt - e0), 64'd2);
        chk("rej_we_cycles", 64'(we_cnt - we0), 64'd0);

        d0 = done_cnt;
        do_start(64'd12, 1);
        send_word(32'hDEADBEEF, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("boundary_byte", imem[12+i], lit_be[i]);
        chk("boundary_done_count", 64'(done_cnt - d0), 64'd1);

        we0 = we_cnt; d0 = done_cnt;
        do_start(64'd4, 0);
        @(negedge clk);
        chk("empty_done_t1", done, 1'b1);
        wait_idle();
        chk("empty_done_count", 64'(done_cnt - d0), 64'd1);
        chk("empty_we_cycles", 64'(we_cnt - we0), 64'd0);

        do_start(64'd0, 1);
        word_valid = 1'b1;
        word_data = 32'hA1B2C3D4;
        model_word(cyc, 32'hA1B2C3D4, n);
        while (cyc < n + 2) tick();
        reset = 1'b1;
        word_valid = 1'b0;
        model_reset(cyc);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_we_off", mem_we, 1'b0);
        chk("rst_mid_busy_off", busy, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) chk("rst_mid_byte", imem[i], lit_rst[i]);
        d0 = done_cnt;
        do_start(64'd0, 1);
        send_word(32'hCAFEF00D, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("after_rst_byte", imem[i], lit_new[i]);
        chk("after_rst_done_count", 64'(done_cnt - d0), 64'd1);
        check_image("final_image");

        reset = 1'b1;
        start = 1'b1;
        base_addr = 64'd0;
        word_count = 8'd1;
        model_reset(cyc);
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        @(negedge clk);
        chk("reset_beats_start_busy", busy, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Write-side companion to the instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each one into the byte-wide instruction memory array as four little-endian byte writes, so the word read back at address A is {byte[A+3], byte[A+2], byte[A+1], byte[A]}. It sits between the program source (testbench, boot ROM or UART front end) and the instruction memory's byte write port, and runs before the core is released from reset.

## Interface

Parameters:
- MEM_BYTES, 16, size of the instruction memory in bytes; must be a multiple of 4.
- COUNT_W, 8, width of the word-count input.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; returns the block to IDLE.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  64  byte address of the first word; sampled with start.
- word_count  input  COUNT_W  number of words to load; sampled with start.
- word_valid  input  1  word_data holds a valid word.
- word_data  input  32  instruction word.
- word_ready  output  1  loader can accept a word this cycle.
- mem_we  output  1  byte write enable to instruction memory.
- mem_addr  output  64  byte write address.
- mem_wdata  output  8  byte write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last byte has been written.
- error  output  1  one-cycle pulse when start is rejected.

## Operation

- States: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE: all outputs 0. On start:
  - Reject if base_addr[1:0] != 0 or base_addr + 4*word_count > MEM_BYTES. Compute the sum at 64+COUNT_W+2 bits so it cannot wrap. On reject, pulse error in the next cycle and stay in IDLE.
  - Otherwise latch addr_ptr = base_addr and remaining = word_count.
  - Go to DONE if word_count == 0, else to WAIT_WORD.
- WAIT_WORD: word_ready=1. Handshake when word_valid && word_ready. On handshake, latch word_data into shift_reg, set byte_idx=0, and go to WRITE.
- WRITE, one byte per cycle:
  - Outputs: mem_we=1, mem_addr=addr_ptr, mem_wdata=shift_reg[7:0].
  - Each cycle: addr_ptr += 1, shift_reg >>= 8, byte_idx += 1.
  - On byte_idx == 3: remaining -= 1. Go to DONE if remaining becomes 0, else to WAIT_WORD.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. It is not queued and produces no error.
- word_valid outside WAIT_WORD is ignored. The source must hold the word until the handshake.
- mem_addr, mem_wdata and mem_we are driven directly from state registers, with no combinational path from inputs.
- Byte order is little-endian: word_data[7:0] goes to addr, [15:8] to addr+1, [23:16] to addr+2, [31:24] to addr+3.

## Timing

- Reset values: state=IDLE, word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, addr_ptr=0, remaining=0.
- start in cycle T, accepted: busy=1 and word_ready=1 from T+1.
- Handshake in cycle N: mem_we=1 in cycles N+1..N+4, with addresses addr, addr+1, addr+2, addr+3. word_ready=1 again at N+5. Throughput is 5 cycles per word.
- Last byte written at cycle L: done=1 at L+1, then busy=0 at L+2.
- word_count == 0: done pulses at T+1 and nothing is written.
- Rejected start at T: error=1 at T+1, and busy stays 0.
- Last word ending exactly at MEM_BYTES-1 is legal. addr_ptr never exceeds MEM_BYTES during a load.
- Reset mid-WRITE: mem_we=0 from the next cycle and state=IDLE. Bytes already written stay in memory; the word is left partially written.
- reset and start in the same cycle: reset wins.

## Test plan

- Load 4 words at base 0: 0x0F053483, 0x009A84B3, 0x00148493, 0x0E953823, with word_valid held high.
  - Required: memory bytes 0..15 = 83 34 05 0F B3 84 9A 00 93 84 14 00 23 38 95 0E.
  - Required: 16 mem_we cycles, done exactly once, and instruction memory reads 0x00148493 at address 8.
- Backpressure: word_valid deasserted for 3 cycles between words. Required: word_ready stays 1, no mem_we during the gap, and the final memory image matches the single-word writes.
- Rejects, each giving one error pulse, no mem_we and busy=0:
  - base_addr=2, word_count=1 (misaligned).
  - base_addr=12, word_count=2 (overflow).
- Boundary and empty loads:
  - base_addr=12, word_count=1, word 0xDEADBEEF: bytes 12..15 = EF BE AD DE and done pulses.
  - word_count=0: done at T+1, no writes.
- Reset after the 2nd byte of a word: mem_we=0 the next cycle, state IDLE, and bytes 0..1 written, 2..3 untouched. Then issue a new start with base 0 and 1 word and check it completes normally.
- start pulsed while busy: ignored, with no error and the in-progress load unaffected.
